alu_issue_ctrl: RTL and testbench
=================================

// Module: alu_issue_ctrl
// PURPOSE
//  Execute-stage issue controller: the driving side of the alu select/operand interface.
//  Decodes RV32I opcode/funct fields and registers the ALU operands and selects.
//  Captures alu_result/comp_result into a result register with a valid/ready output.
//  Sits between the decode stage and writeback/branch logic; the ALU itself stays combinational.
// PARAMETERS
//  OPERAND_LENGTH  32  datapath width of operands/results
//  PC_LENGTH       12  program counter width (zero-extended by the ALU)
// PORTS
//  clk            in   1    system clock, rising edge
//  rst_n          in   1    asynchronous active-low reset
//  in_valid/ready in/out 1  decode-side handshake; transfer when both high
//  in_opcode      in   7    RV32I opcode
//  in_funct3      in   3    funct3 field
//  in_funct7b5    in   1    instr[30] (sub/sra select)
//  in_rs1/in_rs2  in   OL   register operand values
//  in_imm         in   OL   sign-extended immediate
//  in_pc          in   PC   instruction address
//  alu_opd1..4    out  OL   ALU operands (opd3/opd4 = branch compare pair)
//  alu_pc         out  PC   pc to ALU
//  alu_mux1_select out 1    0: compare opd1/opd2, 1: compare opd3/opd4
//  alu_mux2_select out 2    00 adder, 01 logic, 10 shifter, 11 compare
//  alu_op_select  out  3    unit sub-op (table below)
//  alu_pc_select  out  1    0: adder takes opd1, 1: adder takes pc
//  alu_result/comp_result in OL  combinational ALU outputs
//  res_valid/ready out/in 1 result handshake
//  res_data       out  OL   captured result or branch/ld-st target
//  res_taken      out  1    branch outcome (comp_result[0]), 0 for non-branch
//  res_illegal    out  1    unsupported opcode/funct3
// BEHAVIOUR
//  Sub-op codes: adder 000 add / 001 sub.
//  Logic 000 xor / 001 or / 010 and.
//  Shifter 000 sll / 001 srl / 010 sra.
//  Compare uses branch funct3: 000 eq, 001 ne, 100 lt, 101 ge, 110 ltu, 111 geu.
//  OP(0110011)/OP-IMM(0010011): opd1=rs1; opd2=rs2 (OP) or imm (OP-IMM).
//   f3 000 add; sub only if OP and f7b5. f3 001 sll. 101 srl, or sra if f7b5.
//   f3 100 xor, 110 or, 111 and. f3 010 slt -> compare 100, 011 sltu -> compare 110.
//   For slt/sltu: mux1=0, mux2=11, result zero-extended.
//  LUI(0110111): opd1=0, opd2=imm, add. AUIPC(0010111): pc_sel=1, opd2=imm, add.
//  LOAD(0000011)/STORE(0100011): rs1+imm, add.
//  BRANCH(1100011): mux1=1, opd3=rs1, opd4=rs2, op=funct3; pc_sel=1, opd2=imm, mux2=00.
//   res_data=pc+imm (zero-ext pc), res_taken=comp_result[0].
//   Branch f3 010/011 are illegal.
//  Any other opcode, or illegal f3: res_illegal=1, res_data=0, res_taken=0.
//   The illegal op still occupies a slot and completes in order.
//  Pipeline S1 (issue regs drive all alu_* outputs) -> ALU -> S2 (result regs).
//   Latency exactly 2 cycles from accept to res_valid with no stall.
//   Throughput 1 op/cycle.
//  Ready chain: s2_rdy = !res_valid | res_ready; s1_rdy = !s1_valid | s2_rdy; in_ready = s1_rdy.
//  While res_valid & !res_ready: res_* held stable and S1 holds its op (alu_* unchanged).
//  Simultaneous result drain and new accept in one cycle: no bubble.
//  Reset (async, any time): s1_valid=0, res_valid=0, and all data/select regs = 0.
//   In-flight ops are dropped. in_ready=1 on the first edge after rst_n rises.
// TESTING
//  OP f3=000 rs1=5 rs2=7 -> 2 cycles later res_data=12, taken=0, illegal=0.
//  OP f3=000 f7b5=1 rs1=5 rs2=7 -> res_data=0xFFFFFFFE.
//  BEQ rs1=rs2=3 pc=0x100 imm=0x20 -> res_data=0x120, taken=1; same as BNE -> taken=0.
//  SLTU rs1=1 rs2=0xFFFFFFFF -> res_data=1; SLT same operands -> res_data=0.
//  4 back-to-back ADDs, res_ready=0 for 5 cycles -> in_ready low after 2 accepts; all 4 results in order.
//  Opcode 0x7F -> res_illegal=1, data=0; then rst_n low mid-stream -> res_valid=0 immediately.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: execute-stage issue controller driving a combinational ALU.
// Decodes RV32I opcode/funct3/funct7[5], registers the ALU operands and selects
// (stage S1), then captures the ALU result into a result register (stage S2).
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid/in_ready          decode-side handshake
//   in_opcode/funct3/funct7b5  instruction fields
//   in_rs1/in_rs2/in_imm/in_pc operand values
//   alu_opd1..4, alu_pc        registered ALU operands
//   alu_mux1/2_select, alu_op_select, alu_pc_select  registered ALU selects
//   alu_result/comp_result     combinational ALU outputs
//   res_valid/res_ready        result handshake
//   res_data/res_taken/res_illegal  captured result
module alu_issue_ctrl #(
  parameter int unsigned OPERAND_LENGTH = 32,
  parameter int unsigned PC_LENGTH      = 12
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [6:0]                in_opcode,
  input  logic [2:0]                in_funct3,
  input  logic                      in_funct7b5,
  input  logic [OPERAND_LENGTH-1:0] in_rs1,
  input  logic [OPERAND_LENGTH-1:0] in_rs2,
  input  logic [OPERAND_LENGTH-1:0] in_imm,
  input  logic [PC_LENGTH-1:0]      in_pc,
  output logic [OPERAND_LENGTH-1:0] alu_opd1,
  output logic [OPERAND_LENGTH-1:0] alu_opd2,
  output logic [OPERAND_LENGTH-1:0] alu_opd3,
  output logic [OPERAND_LENGTH-1:0] alu_opd4,
  output logic [PC_LENGTH-1:0]      alu_pc,
  output logic                      alu_mux1_select,
  output logic [1:0]                alu_mux2_select,
  output logic [2:0]                alu_op_select,
  output logic                      alu_pc_select,
  input  logic [OPERAND_LENGTH-1:0] alu_result,
  input  logic [OPERAND_LENGTH-1:0] comp_result,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [OPERAND_LENGTH-1:0] res_data,
  output logic                      res_taken,
  output logic                      res_illegal
);

  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;

  // Decoded issue fields
  logic [OPERAND_LENGTH-1:0] dec_opd1, dec_opd2, dec_opd3, dec_opd4;
  logic [PC_LENGTH-1:0]      dec_pc;
  logic                      dec_mux1, dec_pcsel, dec_br, dec_slt, dec_ill;
  logic [1:0]                dec_mux2;
  logic [2:0]                dec_op;

  // S1 (issue) registers
  logic                      s1_valid_q, s1_valid_d;
  logic [OPERAND_LENGTH-1:0] opd1_q, opd2_q, opd3_q, opd4_q;
  logic [PC_LENGTH-1:0]      pc_q;
  logic                      mux1_q, pcsel_q, br_q, slt_q, ill_q;
  logic [1:0]                mux2_q;
  logic [2:0]                op_q;
  logic                      s1_load;

  // S2 (result) registers
  logic                      res_valid_q, res_valid_d;
  logic [OPERAND_LENGTH-1:0] res_data_q, res_data_d;
  logic                      res_taken_q, res_taken_d, res_ill_q, res_ill_d;
  logic                      s2_rdy, s1_rdy, s2_load;

  logic unused_comp;
  assign unused_comp = ^comp_result[OPERAND_LENGTH-1:1];

  always_comb begin
    dec_opd1  = '0;
    dec_opd2  = '0;
    dec_opd3  = '0;
    dec_opd4  = '0;
    dec_pc    = in_pc;
    dec_mux1  = 1'b0;
    dec_mux2  = 2'b00;
    dec_op    = 3'b000;
    dec_pcsel = 1'b0;
    dec_br    = 1'b0;
    dec_slt   = 1'b0;
    dec_ill   = 1'b0;
    case (in_opcode)
      OpcOp, OpcOpImm: begin
        dec_opd1 = in_rs1;
        dec_opd2 = (in_opcode == OpcOp) ? in_rs2 : in_imm;
        case (in_funct3)
          3'b000: dec_op = (in_opcode == OpcOp && in_funct7b5) ? 3'b001 : 3'b000;
          3'b001: dec_mux2 = 2'b10;
          3'b010: begin dec_mux2 = 2'b11; dec_op = 3'b100; dec_slt = 1'b1; end
          3'b011: begin dec_mux2 = 2'b11; dec_op = 3'b110; dec_slt = 1'b1; end
          3'b100: dec_mux2 = 2'b01;
          3'b101: begin dec_mux2 = 2'b10; dec_op = in_funct7b5 ? 3'b010 : 3'b001; end
          3'b110: begin dec_mux2 = 2'b01; dec_op = 3'b001; end
          default: begin dec_mux2 = 2'b01; dec_op = 3'b010; end
        endcase
      end
      OpcLui: dec_opd2 = in_imm;
      OpcAuipc: begin dec_pcsel = 1'b1; dec_opd2 = in_imm; end
      OpcLoad, OpcStore: begin dec_opd1 = in_rs1; dec_opd2 = in_imm; end
      OpcBranch: begin
        if (in_funct3[2:1] == 2'b01) begin
          dec_ill = 1'b1;
        end else begin
          dec_mux1  = 1'b1;
          dec_opd3  = in_rs1;
          dec_opd4  = in_rs2;
          dec_op    = in_funct3;
          dec_pcsel = 1'b1;
          dec_opd2  = in_imm;
          dec_br    = 1'b1;
        end
      end
      default: dec_ill = 1'b1;
    endcase
    if (dec_ill) dec_pc = '0;
  end

  // Ready chain: a stalled result freezes S2, which in turn freezes a full S1.
  assign s2_rdy   = !res_valid_q | res_ready;
  assign s1_rdy   = !s1_valid_q | s2_rdy;
  assign in_ready = s1_rdy;
  assign s1_load  = in_valid & s1_rdy;
  assign s2_load  = s1_valid_q & s2_rdy;

  always_comb begin
    s1_valid_d  = s1_rdy ? in_valid : s1_valid_q;
    res_valid_d = s2_rdy ? s1_valid_q : res_valid_q;
    res_data_d  = res_data_q;
    res_taken_d = res_taken_q;
    res_ill_d   = res_ill_q;
    if (s2_load) begin
      res_taken_d = 1'b0;
      res_ill_d   = ill_q;
      if (ill_q) begin
        res_data_d = '0;
      end else if (br_q) begin
        // Target is formed here: op_select carries the compare code on branches.
        res_data_d  = {{(OPERAND_LENGTH-PC_LENGTH){1'b0}}, pc_q} + opd2_q;
        res_taken_d = comp_result[0];
      end else if (slt_q) begin
        res_data_d = {{(OPERAND_LENGTH-1){1'b0}}, comp_result[0]};
      end else begin
        res_data_d = alu_result;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      opd1_q      <= '0;
      opd2_q      <= '0;
      opd3_q      <= '0;
      opd4_q      <= '0;
      pc_q        <= '0;
      mux1_q      <= 1'b0;
      mux2_q      <= 2'b00;
      op_q        <= 3'b000;
      pcsel_q     <= 1'b0;
      br_q        <= 1'b0;
      slt_q       <= 1'b0;
      ill_q       <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_taken_q <= 1'b0;
      res_ill_q   <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_taken_q <= res_taken_d;
      res_ill_q   <= res_ill_d;
      if (s1_load) begin
        opd1_q  <= dec_opd1;
        opd2_q  <= dec_opd2;
        opd3_q  <= dec_opd3;
        opd4_q  <= dec_opd4;
        pc_q    <= dec_pc;
        mux1_q  <= dec_mux1;
        mux2_q  <= dec_mux2;
        op_q    <= dec_op;
        pcsel_q <= dec_pcsel;
        br_q    <= dec_br;
        slt_q   <= dec_slt;
        ill_q   <= dec_ill;
      end
    end
  end

  assign alu_opd1        = opd1_q;
  assign alu_opd2        = opd2_q;
  assign alu_opd3        = opd3_q;
  assign alu_opd4        = opd4_q;
  assign alu_pc          = pc_q;
  assign alu_mux1_select = mux1_q;
  assign alu_mux2_select = mux2_q;
  assign alu_op_select   = op_q;
  assign alu_pc_select   = pcsel_q;
  assign res_valid       = res_valid_q;
  assign res_data        = res_data_q;
  assign res_taken       = res_taken_q;
  assign res_illegal     = res_ill_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: an ALU model closes the loop; a scoreboard queue holds
// expected results computed straight from instruction semantics.
module tb_alu_issue_ctrl;
  localparam int unsigned OL = 32;
  localparam int unsigned PL = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0, in_ready;
  logic [6:0]    in_opcode = '0;
  logic [2:0]    in_funct3 = '0;
  logic          in_funct7b5 = 1'b0;
  logic [OL-1:0] in_rs1 = '0, in_rs2 = '0, in_imm = '0;
  logic [PL-1:0] in_pc = '0;
  logic [OL-1:0] alu_opd1, alu_opd2, alu_opd3, alu_opd4;
  logic [PL-1:0] alu_pc;
  logic          alu_mux1_select, alu_pc_select;
  logic [1:0]    alu_mux2_select;
  logic [2:0]    alu_op_select;
  logic [OL-1:0] alu_result, comp_result;
  logic          res_valid, res_ready = 1'b1;
  logic [OL-1:0] res_data;
  logic          res_taken, res_illegal;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.OPERAND_LENGTH(OL), .PC_LENGTH(PL)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_pc(in_pc),
    .alu_opd1(alu_opd1), .alu_opd2(alu_opd2), .alu_opd3(alu_opd3), .alu_opd4(alu_opd4),
    .alu_pc(alu_pc), .alu_mux1_select(alu_mux1_select), .alu_mux2_select(alu_mux2_select),
    .alu_op_select(alu_op_select), .alu_pc_select(alu_pc_select),
    .alu_result(alu_result), .comp_result(comp_result),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_taken(res_taken), .res_illegal(res_illegal)
  );

  // Combinational ALU the controller drives.
  logic [OL-1:0] a_in, ca, cb;
  logic          cmp;
  always_comb begin
    a_in = alu_pc_select ? {20'b0, alu_pc} : alu_opd1;
    ca   = alu_mux1_select ? alu_opd3 : alu_opd1;
    cb   = alu_mux1_select ? alu_opd4 : alu_opd2;
    cmp  = 1'b0;
    case (alu_op_select)
      3'b000: cmp = (ca == cb);
      3'b001: cmp = (ca != cb);
      3'b100: cmp = ($signed(ca) < $signed(cb));
      3'b101: cmp = ($signed(ca) >= $signed(cb));
      3'b110: cmp = (ca < cb);
      3'b111: cmp = (ca >= cb);
      default: cmp = 1'b0;
    endcase
    comp_result = {31'b0, cmp};
    alu_result  = '0;
    case (alu_mux2_select)
      2'b00: alu_result = (alu_op_select == 3'b001) ? a_in - alu_opd2 : a_in + alu_opd2;
      2'b01: alu_result = (alu_op_select == 3'b000) ? alu_opd1 ^ alu_opd2 :
                          (alu_op_select == 3'b001) ? alu_opd1 | alu_opd2 : alu_opd1 & alu_opd2;
      2'b10: alu_result = (alu_op_select == 3'b000) ? alu_opd1 << alu_opd2[4:0] :
                          (alu_op_select == 3'b001) ? alu_opd1 >> alu_opd2[4:0] :
                          OL'($signed(alu_opd1) >>> alu_opd2[4:0]);
      default: alu_result = {31'b0, cmp};
    endcase
  end

  typedef struct packed {
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        f7;
    logic [31:0] rs1, rs2, imm;
    logic [11:0] pc;
  } instr_t;
  typedef struct packed {
    logic [31:0] data;
    logic        taken;
    logic        ill;
  } exp_t;

  exp_t   exp_q[$];
  instr_t stim_q[$];
  int     errors = 0;
  int     checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: RV32I semantics in plain arithmetic.
  function automatic exp_t model(input instr_t i);
    exp_t        e;
    logic [31:0] b, pcx;
    e   = '0;
    pcx = {20'b0, i.pc};
    b   = (i.opc == 7'b0110011) ? i.rs2 : i.imm;
    case (i.opc)
      7'b0110011, 7'b0010011: begin
        case (i.f3)
          3'd0: e.data = (i.opc == 7'b0110011 && i.f7) ? i.rs1 - b : i.rs1 + b;
          3'd1: e.data = i.rs1 << b[4:0];
          3'd2: e.data = {31'b0, $signed(i.rs1) < $signed(b)};
          3'd3: e.data = {31'b0, i.rs1 < b};
          3'd4: e.data = i.rs1 ^ b;
          3'd5: e.data = i.f7 ? 32'($signed(i.rs1) >>> b[4:0]) : i.rs1 >> b[4:0];
          3'd6: e.data = i.rs1 | b;
          default: e.data = i.rs1 & b;
        endcase
      end
      7'b0110111: e.data = i.imm;
      7'b0010111: e.data = pcx + i.imm;
      7'b0000011, 7'b0100011: e.data = i.rs1 + i.imm;
      7'b1100011: begin
        if (i.f3 == 3'd2 || i.f3 == 3'd3) begin
          e.ill = 1'b1;
        end else begin
          e.data = pcx + i.imm;
          case (i.f3)
            3'd0: e.taken = (i.rs1 == i.rs2);
            3'd1: e.taken = (i.rs1 != i.rs2);
            3'd4: e.taken = ($signed(i.rs1) < $signed(i.rs2));
            3'd5: e.taken = ($signed(i.rs1) >= $signed(i.rs2));
            3'd6: e.taken = (i.rs1 < i.rs2);
            default: e.taken = (i.rs1 >= i.rs2);
          endcase
        end
      end
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  function automatic instr_t mk(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                                input logic [31:0] rs1, input logic [31:0] rs2,
                                input logic [31:0] imm, input logic [11:0] pc);
    instr_t i;
    i.opc = opc; i.f3 = f3; i.f7 = f7; i.rs1 = rs1; i.rs2 = rs2; i.imm = imm; i.pc = pc;
    return i;
  endfunction

  function automatic instr_t rand_instr();
    logic [6:0] opc;
    case ($urandom_range(0, 9))
      0, 1: opc = 7'b0110011;
      2, 3: opc = 7'b0010011;
      4: opc = 7'b0110111;
      5: opc = 7'b0010111;
      6: opc = 7'b0000011;
      7: opc = 7'b0100011;
      8: opc = 7'b1100011;
      default: opc = 7'($urandom);
    endcase
    return mk(opc, 3'($urandom), 1'($urandom), $urandom, $urandom_range(0, 3) == 0 ? 32'd7 :
              $urandom, $urandom, 12'($urandom));
  endfunction

  task automatic apply(input instr_t i);
    in_opcode = i.opc; in_funct3 = i.f3; in_funct7b5 = i.f7;
    in_rs1 = i.rs1; in_rs2 = i.rs2; in_imm = i.imm; in_pc = i.pc;
  endtask

  // Monitor: push on accept, pop and compare on result transfer, check hold while stalled.
  initial begin
    exp_t held;
    exp_t e;
    bit   held_v;
    held_v = 1'b0;
    held   = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held_v = 1'b0;
      end else begin
        if (held_v) begin
          check("hold_valid", 32'(res_valid), 32'd1);
          check("hold_data", res_data, held.data);
        end
        if (in_valid && in_ready)
          exp_q.push_back(model(mk(in_opcode, in_funct3, in_funct7b5, in_rs1, in_rs2,
                                   in_imm, in_pc)));
        if (res_valid && res_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_result", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("res_data", res_data, e.data);
            check("res_taken", 32'(res_taken), 32'(e.taken));
            check("res_illegal", 32'(res_illegal), 32'(e.ill));
          end
        end
        held_v = res_valid && !res_ready;
        held   = {res_data, res_taken, res_illegal};
      end
    end
  end

  // mode 0: always ready, 1: ready low for 5 cycles, 2: random ready and gaps.
  task automatic play(input int mode);
    int total, acc, c;
    bit taken;
    total = stim_q.size();
    acc = 0; c = 0; taken = 1'b0;
    while (acc < total && c < 5000) begin
      @(posedge clk); #1;
      if (taken) in_valid = 1'b0;
      case (mode)
        0: res_ready = 1'b1;
        1: res_ready = (c >= 5);
        default: res_ready = ($urandom_range(0, 3) != 0);
      endcase
      if (!in_valid && stim_q.size() > 0 && !(mode == 2 && $urandom_range(0, 3) == 0)) begin
        apply(stim_q.pop_front());
        in_valid = 1'b1;
      end
      @(negedge clk);
      if (mode == 0 && c == 1) check("latency_not_early", 32'(res_valid), 32'd0);
      if (mode == 0 && c == 2) check("latency_two", 32'(res_valid), 32'd1);
      if (mode == 1 && c == 3) begin
        check("bp_accepts", acc, 32'd2);
        check("bp_in_ready", 32'(in_ready), 32'd0);
      end
      taken = in_valid && in_ready;
      if (taken) acc++;
      c++;
    end
    if (acc < total) check("accept_timeout", acc, total);
    @(posedge clk); #1;
    in_valid  = 1'b0;
    res_ready = 1'b1;
    for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(negedge clk);
    @(negedge clk);
    check("drain", exp_q.size(), 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_data", res_data, 32'd0);
    check("rst_opd1", alu_opd1, 32'd0);
    check("rst_mux2", 32'(alu_mux2_select), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Directed cases, back-to-back with result always accepted.
    stim_q.push_back(mk(7'b0110011, 3'd0, 1'b0, 32'd5, 32'd7, 32'd0, 12'h000));
    stim_q.push_back(mk(7'b0110011, 3'd0, 1'b1, 32'd5, 32'd7, 32'd0, 12'h000));
    stim_q.push_back(mk(7'b1100011, 3'd0, 1'b0, 32'd3, 32'd3, 32'h20, 12'h100));
    stim_q.push_back(mk(7'b1100011, 3'd1, 1'b0, 32'd3, 32'd3, 32'h20, 12'h100));
    stim_q.push_back(mk(7'b0110011, 3'd3, 1'b0, 32'd1, 32'hFFFF_FFFF, 32'd0, 12'h000));
    stim_q.push_back(mk(7'b0110011, 3'd2, 1'b0, 32'd1, 32'hFFFF_FFFF, 32'd0, 12'h000));
    stim_q.push_back(mk(7'b1111111, 3'd0, 1'b0, 32'd9, 32'd9, 32'd9, 12'h0AB));
    stim_q.push_back(mk(7'b1100011, 3'd2, 1'b0, 32'd1, 32'd2, 32'd4, 12'h010));
    stim_q.push_back(mk(7'b0110111, 3'd0, 1'b0, 32'd1, 32'd2, 32'hABCD_E000, 12'h010));
    stim_q.push_back(mk(7'b0010111, 3'd0, 1'b0, 32'd1, 32'd2, 32'hFFFF_FFF0, 12'hFFF));
    stim_q.push_back(mk(7'b0010011, 3'd5, 1'b1, 32'h8000_0000, 32'd0, 32'd4, 12'h000));
    play(0);

    // Four ADDs against a stalled result port.
    for (int k = 0; k < 4; k++)
      stim_q.push_back(mk(7'b0110011, 3'd0, 1'b0, 32'(k * 10), 32'd1, 32'd0, 12'h000));
    play(1);

    for (int k = 0; k < 300; k++) stim_q.push_back(rand_instr());
    play(2);

    // Reset while two ops are in flight.
    res_ready = 1'b0;
    @(posedge clk); #1;
    apply(mk(7'b0110011, 3'd0, 1'b0, 32'd1, 32'd2, 32'd0, 12'h001));
    in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("pre_reset_valid", 32'(res_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(res_valid), 32'd0);
    check("async_rst_data", res_data, 32'd0);
    check("async_rst_opd2", alu_opd2, 32'd0);
    exp_q.delete();
    res_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    check("post_rst_res_valid", 32'(res_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
